// File: rtl/conv_ctrl_param_cu.sv
// Conv2d control unit: sequences kernel BRAM/register loads and first/mid/last row streaming per in/out channel.
// Optional stall counter output enabled by defining CONV_CU_PERF_CNT_EN.
module conv_ctrl_param_cu #(
    parameter int unsigned ROW_W   = 8,
    parameter int unsigned CH_W    = 9,
    parameter int unsigned OCH_W   = 9,
    parameter int unsigned KSIZE   = 3,
    parameter int unsigned MAX_IMG = 128
) (
    input  logic              clk,
    input  logic              Reset_top,
    input  logic              start,
    input  logic [ROW_W-1:0]  cfg_img_size,
    input  logic [CH_W-1:0]   cfg_in_ch,
    input  logic [OCH_W-1:0]  cfg_out_ch,
    input  logic              Kernel_BRAM_IDLE,
    input  logic              last_loading_1ker,
    input  logic              PE_ready,
    input  logic              Input_line_buffer_IDLE,
    input  logic              PE_with_buffers_IDLE,
    input  logic              Done_1row,
    output logic              load_BRAM_dina,
    output logic              Load_kernel_reg,
    output logic              update_BRAM_doutb,
    output logic              Stream_first_row,
    output logic              Stream_mid_row,
    output logic              Stream_last_row,
    output logic [ROW_W-1:0]  row_idx,
    output logic [CH_W-1:0]   in_ch_idx,
    output logic [OCH_W-1:0]  out_ch_idx,
    output logic              acc_clear,
    output logic              acc_emit,
    output logic              busy,
    output logic              conv_DONE,
`ifdef CONV_CU_PERF_CNT_EN
    output logic [31:0]       stall_cycles,
`endif
    output logic              cfg_err
);

    localparam int unsigned PAD = KSIZE / 2;
    localparam logic [ROW_W-1:0] KSIZE_R = ROW_W'(KSIZE);
    localparam logic [ROW_W-1:0] MAX_R   = ROW_W'(MAX_IMG);
    localparam logic [ROW_W-1:0] PAD_R   = ROW_W'(PAD);

    typedef enum logic [3:0] {
        IDLE, WAIT_BRAM, LOAD_BRAM, LOAD_KREG, WAIT_IDLE,
        STREAM, WAIT_ROW, WAIT_UPD, UPDATE, DONE
    } state_t;

    state_t            state, state_nx;
    logic [ROW_W-1:0]  img_cfg, img_nx;
    logic [CH_W-1:0]   in_ch_cfg, in_ch_nx;
    logic [OCH_W-1:0]  out_ch_cfg, out_ch_nx;
    logic [ROW_W-1:0]  row_nx;
    logic [CH_W-1:0]   in_idx_nx;
    logic [OCH_W-1:0]  out_idx_nx;
    logic              err_nx;
    logic              cfg_ok;
    logic              idles_ok;
    logic              lb_nx, lk_nx, upd_nx, sf_nx, sm_nx, sl_nx;
    logic              clr_nx, emit_nx, busy_nx, done_nx;

    always_comb begin
        cfg_ok   = (cfg_img_size >= KSIZE_R) && (cfg_img_size <= MAX_R)
                && (cfg_in_ch != '0) && (cfg_out_ch != '0);
        idles_ok = Input_line_buffer_IDLE && PE_with_buffers_IDLE;
    end

    // Next state, next indices, and output decode of the next state so outputs are registered Moore.
    always_comb begin
        state_nx   = state;
        img_nx     = img_cfg;
        in_ch_nx   = in_ch_cfg;
        out_ch_nx  = out_ch_cfg;
        row_nx     = row_idx;
        in_idx_nx  = in_ch_idx;
        out_idx_nx = out_ch_idx;
        err_nx     = cfg_err;

        case (state)
            IDLE: begin
                if (start) begin
                    if (cfg_ok) begin
                        img_nx     = cfg_img_size;
                        in_ch_nx   = cfg_in_ch;
                        out_ch_nx  = cfg_out_ch;
                        row_nx     = '0;
                        in_idx_nx  = '0;
                        out_idx_nx = '0;
                        err_nx     = 1'b0;
                        state_nx   = WAIT_BRAM;
                    end else begin
                        err_nx = 1'b1;
                    end
                end
            end
            WAIT_BRAM: if (Kernel_BRAM_IDLE)  state_nx = LOAD_BRAM;
            LOAD_BRAM: if (last_loading_1ker) state_nx = LOAD_KREG;
            LOAD_KREG: if (PE_ready)          state_nx = WAIT_IDLE;
            WAIT_IDLE: if (idles_ok)          state_nx = STREAM;
            STREAM:    state_nx = WAIT_ROW;
            WAIT_ROW: begin
                if (Done_1row) begin
                    if (row_idx < img_cfg - ROW_W'(1)) begin
                        row_nx   = row_idx + ROW_W'(1);
                        state_nx = WAIT_IDLE;
                    end else begin
                        row_nx   = '0;
                        state_nx = WAIT_UPD;
                    end
                end
            end
            WAIT_UPD: if (idles_ok) state_nx = UPDATE;
            UPDATE: begin
                if (in_ch_idx < in_ch_cfg - CH_W'(1)) begin
                    in_idx_nx = in_ch_idx + CH_W'(1);
                    state_nx  = LOAD_KREG;
                end else begin
                    in_idx_nx = '0;
                    if (out_ch_idx < out_ch_cfg - OCH_W'(1)) begin
                        out_idx_nx = out_ch_idx + OCH_W'(1);
                        state_nx   = WAIT_BRAM;
                    end else begin
                        out_idx_nx = '0;
                        row_nx     = '0;
                        state_nx   = DONE;
                    end
                end
            end
            DONE: begin
                row_nx     = '0;
                in_idx_nx  = '0;
                out_idx_nx = '0;
                state_nx   = IDLE;
            end
            default: state_nx = IDLE;
        endcase

        lb_nx   = (state_nx == LOAD_BRAM);
        lk_nx   = (state_nx == LOAD_KREG);
        upd_nx  = (state_nx == UPDATE);
        busy_nx = (state_nx != IDLE);
        done_nx = (state_nx == DONE);
        sf_nx   = (state_nx == STREAM) && (row_nx < PAD_R);
        sl_nx   = (state_nx == STREAM) && !sf_nx && (row_nx >= img_nx - PAD_R);
        sm_nx   = (state_nx == STREAM) && !sf_nx && !sl_nx;
        clr_nx  = busy_nx && (in_idx_nx == '0);
        emit_nx = busy_nx && (in_idx_nx == in_ch_nx - CH_W'(1));
    end

    always_ff @(posedge clk or posedge Reset_top) begin
        if (Reset_top) begin
            state             <= IDLE;
            img_cfg           <= '0;
            in_ch_cfg         <= '0;
            out_ch_cfg        <= '0;
            row_idx           <= '0;
            in_ch_idx         <= '0;
            out_ch_idx        <= '0;
            cfg_err           <= 1'b0;
            load_BRAM_dina    <= 1'b0;
            Load_kernel_reg   <= 1'b0;
            update_BRAM_doutb <= 1'b0;
            Stream_first_row  <= 1'b0;
            Stream_mid_row    <= 1'b0;
            Stream_last_row   <= 1'b0;
            acc_clear         <= 1'b0;
            acc_emit          <= 1'b0;
            busy              <= 1'b0;
            conv_DONE         <= 1'b0;
        end else begin
            state             <= state_nx;
            img_cfg           <= img_nx;
            in_ch_cfg         <= in_ch_nx;
            out_ch_cfg        <= out_ch_nx;
            row_idx           <= row_nx;
            in_ch_idx         <= in_idx_nx;
            out_ch_idx        <= out_idx_nx;
            cfg_err           <= err_nx;
            load_BRAM_dina    <= lb_nx;
            Load_kernel_reg   <= lk_nx;
            update_BRAM_doutb <= upd_nx;
            Stream_first_row  <= sf_nx;
            Stream_mid_row    <= sm_nx;
            Stream_last_row   <= sl_nx;
            acc_clear         <= clr_nx;
            acc_emit          <= emit_nx;
            busy              <= busy_nx;
            conv_DONE         <= done_nx;
        end
    end

`ifdef CONV_CU_PERF_CNT_EN
    logic stall_now;

    always_comb begin
        stall_now = (((state == WAIT_IDLE) || (state == WAIT_UPD)) && !idles_ok)
                 || ((state == LOAD_KREG) && !PE_ready);
    end

    // Saturating count of cycles spent waiting on the datapath; restarts with each accepted job.
    always_ff @(posedge clk or posedge Reset_top) begin
        if (Reset_top) begin
            stall_cycles <= '0;
        end else if ((state == IDLE) && start && cfg_ok) begin
            stall_cycles <= '0;
        end else if (stall_now && (stall_cycles != '1)) begin
            stall_cycles <= stall_cycles + 32'(1);
        end
    end
`endif

endmodule

// File: tb/tb_conv_ctrl_param_cu.sv
// Bench for conv_ctrl_param_cu: KSIZE=3 and KSIZE=5 instances, stream-event scoreboard plus directed checks.
`timescale 1ns/1ps
module tb_conv_ctrl_param_cu;

    typedef struct packed {
        logic [2:0] kind;   // {first, mid, last}
        logic [7:0] row;
        logic [8:0] ich;
        logic [8:0] och;
        logic       clr;
        logic       emit;
    } ev_t;

    logic       clk = 1'b0;
    logic       Reset_top;
    logic       start, start5;
    logic [7:0] cfg_img_size;
    logic [8:0] cfg_in_ch, cfg_out_ch;
    logic       Kernel_BRAM_IDLE, last_loading_1ker, PE_ready;
    logic       Input_line_buffer_IDLE, PE_with_buffers_IDLE, Done_1row;

    logic       lb[2], lk[2], upd[2], sf[2], sm[2], sl[2];
    logic [7:0] row[2];
    logic [8:0] ich[2], och[2];
    logic       clr[2], emit[2], busy[2], done[2], err[2];
`ifdef CONV_CU_PERF_CNT_EN
    logic [31:0] stall[2];
`endif

    int   n_cmp = 0;
    int   n_err = 0;
    int   n_stream[2], n_upd[2], n_lb[2], n_done[2];
    ev_t  exp_q[2][$];
    ev_t  obs_ev, exp_ev;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        conv_ctrl_param_cu #(.KSIZE(3 + 2 * g)) u_dut (
            .clk                    (clk),
            .Reset_top              (Reset_top),
            .start                  ((g == 0) ? start : start5),
            .cfg_img_size           (cfg_img_size),
            .cfg_in_ch              (cfg_in_ch),
            .cfg_out_ch             (cfg_out_ch),
            .Kernel_BRAM_IDLE       (Kernel_BRAM_IDLE),
            .last_loading_1ker      (last_loading_1ker),
            .PE_ready               (PE_ready),
            .Input_line_buffer_IDLE (Input_line_buffer_IDLE),
            .PE_with_buffers_IDLE   (PE_with_buffers_IDLE),
            .Done_1row              (Done_1row),
            .load_BRAM_dina         (lb[g]),
            .Load_kernel_reg        (lk[g]),
            .update_BRAM_doutb      (upd[g]),
            .Stream_first_row       (sf[g]),
            .Stream_mid_row         (sm[g]),
            .Stream_last_row        (sl[g]),
            .row_idx                (row[g]),
            .in_ch_idx              (ich[g]),
            .out_ch_idx             (och[g]),
            .acc_clear              (clr[g]),
            .acc_emit               (emit[g]),
            .busy                   (busy[g]),
            .conv_DONE              (done[g]),
`ifdef CONV_CU_PERF_CNT_EN
            .stall_cycles           (stall[g]),
`endif
            .cfg_err                (err[g])
        );
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] outs(input int g);
        return 64'({lb[g], lk[g], upd[g], sf[g], sm[g], sl[g], row[g], ich[g], och[g],
                    clr[g], emit[g], busy[g], done[g], err[g]});
    endfunction

    // Scoreboard consumer: every row-start pulse is matched against the next expected event.
    always @(negedge clk) begin
        if (!Reset_top) begin
            for (int g = 0; g < 2; g++) begin
                if (sf[g] || sm[g] || sl[g]) begin
                    n_stream[g]++;
                    obs_ev = {sf[g], sm[g], sl[g], row[g], ich[g], och[g], clr[g], emit[g]};
                    if (exp_q[g].size() == 0) begin
                        check("stream_unexpected", 64'(obs_ev), 64'(0));
                    end else begin
                        exp_ev = exp_q[g].pop_front();
                        check("stream_event", 64'(obs_ev), 64'(exp_ev));
                    end
                end
                if (upd[g]) n_upd[g]++;
                if (lb[g])  n_lb[g]++;
                if (done[g]) begin
                    n_done[g]++;
                    check("done_indices", 64'({row[g], ich[g], och[g]}), 64'(0));
                end
            end
        end
    end

    task automatic push_job(input int g, input int img, input int ic, input int oc);
        ev_t e;
        int  pad;
        pad = (g == 0) ? 1 : 2;
        for (int o = 0; o < oc; o++)
            for (int i = 0; i < ic; i++)
                for (int r = 0; r < img; r++) begin
                    e.kind = (r < pad) ? 3'b100 : (r >= img - pad) ? 3'b001 : 3'b010;
                    e.row  = 8'(r);
                    e.ich  = 9'(i);
                    e.och  = 9'(o);
                    e.clr  = (i == 0);
                    e.emit = (i == ic - 1);
                    exp_q[g].push_back(e);
                end
    endtask

    task automatic pulse_start(input int g, input int img, input int ic, input int oc);
        @(posedge clk); #1;
        cfg_img_size = 8'(img);
        cfg_in_ch    = 9'(ic);
        cfg_out_ch   = 9'(oc);
        if (g == 0) start = 1'b1; else start5 = 1'b1;
        @(posedge clk); #1;
        start  = 1'b0;
        start5 = 1'b0;
    endtask

    task automatic start_job(input int g, input int img, input int ic, input int oc);
        push_job(g, img, ic, oc);
        n_upd[g]  = 0;
        n_lb[g]   = 0;
        n_done[g] = 0;
        pulse_start(g, img, ic, oc);
        check("busy_after_start", 64'(busy[g]), 64'(1));
        check("err_after_start", 64'(err[g]), 64'(0));
    endtask

    task automatic finish_job(input int g, input int ic, input int oc);
        bit seen;
        seen = 1'b0;
        for (int c = 0; c < 5000 && !seen; c++) begin
            @(negedge clk);
            if (done[g]) seen = 1'b1;
        end
        check("done_seen", 64'(seen), 64'(1));
        @(negedge clk);
        check("busy_after_done", 64'(busy[g]), 64'(0));
        check("stream_left", 64'(exp_q[g].size()), 64'(0));
        check("update_pulses", 64'(n_upd[g]), 64'(ic * oc));
        check("load_bram_cycles", 64'(n_lb[g]), 64'(oc));
        check("done_pulses", 64'(n_done[g]), 64'(1));
    endtask

    task automatic run_job(input int g, input int img, input int ic, input int oc);
        start_job(g, img, ic, oc);
        finish_job(g, ic, oc);
    endtask

    initial begin
        int  cnt0;
        bit  hit;
        Reset_top              = 1'b1;
        start                  = 1'b0;
        start5                 = 1'b0;
        cfg_img_size           = '0;
        cfg_in_ch              = '0;
        cfg_out_ch             = '0;
        Kernel_BRAM_IDLE       = 1'b1;
        last_loading_1ker      = 1'b1;
        PE_ready               = 1'b1;
        Input_line_buffer_IDLE = 1'b1;
        PE_with_buffers_IDLE   = 1'b1;
        Done_1row              = 1'b1;
        for (int g = 0; g < 2; g++) begin
            n_stream[g] = 0; n_upd[g] = 0; n_lb[g] = 0; n_done[g] = 0;
        end
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs_k3", outs(0), 64'(0));
        check("reset_outputs_k5", outs(1), 64'(0));
        Reset_top = 1'b0;

        // Two input channels, one filter: first,mid,mid,last per channel.
        run_job(0, 4, 2, 1);
`ifdef CONV_CU_PERF_CNT_EN
        check("stall_free_run", 64'(stall[0]), 64'(0));
`endif
        // Three filters: BRAM reloaded per filter, clear and emit both high with one input channel.
        run_job(0, 8, 1, 3);
        // Rejected configurations leave the unit idle with a sticky error.
        pulse_start(0, 2, 1, 1);
        check("err_img_small", 64'({err[0], busy[0]}), 64'(2'b10));
        pulse_start(0, 4, 0, 1);
        check("err_in_ch_zero", 64'({err[0], busy[0]}), 64'(2'b10));
        pulse_start(0, 129, 1, 1);
        check("err_img_large", 64'({err[0], busy[0]}), 64'(2'b10));
        pulse_start(0, 4, 1, 0);
        check("err_out_ch_zero", 64'({err[0], busy[0]}), 64'(2'b10));
        run_job(0, 4, 1, 1);
        // KSIZE=5 edge rows.
        run_job(1, 8, 1, 1);
        check("k3_idle_during_k5", 64'(busy[0]), 64'(0));
        // Loop boundaries: smallest and largest image, multi-channel both dimensions.
        run_job(0, 3, 1, 1);
        run_job(0, 128, 1, 1);
        run_job(0, 5, 3, 2);
        run_job(1, 5, 2, 2);

        // PE idle held low for 10 cycles in WAIT_IDLE blocks streaming.
        start_job(0, 4, 1, 1);
        hit = 1'b0;
        for (int c = 0; c < 200 && !hit; c++) begin
            @(negedge clk);
            if (sf[0]) hit = 1'b1;
        end
        check("first_stream_seen", 64'(hit), 64'(1));
        #1;
        PE_with_buffers_IDLE = 1'b0;
        cnt0 = n_stream[0];
        repeat (12) @(posedge clk);
        #1;
        check("no_stream_while_stalled", 64'(n_stream[0]), 64'(cnt0));
        PE_with_buffers_IDLE = 1'b1;
        finish_job(0, 1, 1);
`ifdef CONV_CU_PERF_CNT_EN
        check("stall_cycles", 64'(stall[0]), 64'(10));
`endif

        // Asynchronous reset in the middle of row 3 aborts the job at once.
        start_job(0, 8, 1, 1);
        hit = 1'b0;
        for (int c = 0; c < 200 && !hit; c++) begin
            @(negedge clk);
            if (sm[0] && row[0] == 8'd3) hit = 1'b1;
        end
        check("row3_seen", 64'(hit), 64'(1));
        #1;
        Reset_top = 1'b1;
        #1;
        check("reset_mid_row", outs(0), 64'(0));
        exp_q[0].delete();
        @(posedge clk); #1;
        Reset_top = 1'b0;
        run_job(0, 8, 2, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
